dispatch_ctrl: RTL

- Downstream neighbour of the 4-wide decoder. Captures one decoded group (up to 4 slots, slot0 oldest) in a holding register.
- Dispatches slots in program order to two reservation stations (RS0/RS1), selected by each slot's rs_id. Each RS has 2 write ports per cycle.
- Tracks free RS entries with credit counters, back-pressures decode, and halts on an illegal instruction until retire flush.

---
 rtl/dispatch_ctrl_if.sv | 24 ++
 rtl/dispatch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_ctrl_if.sv
// Decode-to-dispatch group handshake.
// Decoder drives the master side, dispatch_ctrl the slave side.
interface dispatch_ctrl_if #(
  parameter int PAYLOAD_W = 29
);
  logic [3:0]             dec_vld_i;
  logic [4*PAYLOAD_W-1:0] dec_payload_i;
  logic [3:0]             dec_rs_id_i;
  logic                   dec_ready_o;

  modport master (
    output dec_vld_i,
    output dec_payload_i,
    output dec_rs_id_i,
    input  dec_ready_o
  );

  modport slave (
    input  dec_vld_i,
    input  dec_payload_i,
    input  dec_rs_id_i,
    output dec_ready_o
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// In-order 4-slot dispatch into two 2-port reservation stations.
// Optional stall counter: define DISPATCH_PERF_CNT_EN.
module dispatch_ctrl #(
  parameter int PAYLOAD_W = 29,
  parameter int RS_DEPTH  = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   retire_flush_i,
  dispatch_ctrl_if.slave         dec,
  output logic [1:0]             rs0_wr_vld_o,
  output logic [2*PAYLOAD_W-1:0] rs0_wr_data_o,
  output logic [1:0]             rs1_wr_vld_o,
  output logic [2*PAYLOAD_W-1:0] rs1_wr_data_o,
  input  logic [1:0]             rs0_free_i,
  input  logic [1:0]             rs1_free_i,
  output logic                   illegal_o,
  output logic [1:0]             illegal_slot_o,
  output logic [31:0]            stall_cnt_o
);

  localparam int SW = CNT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH =
    CNT_W'(RS_DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             grp_vld_q, grp_vld_d;
  logic [3:0]             grp_rs_q, grp_rs_d;
  logic [PAYLOAD_W-1:0]   grp_pay_q [4];
  logic [PAYLOAD_W-1:0]   grp_pay_d [4];
  logic [CNT_W-1:0]       credit0_q, credit0_d;
  logic [CNT_W-1:0]       credit1_q, credit1_d;

  logic                   run;
  logic                   flush;
  logic [3:0]             disp;
  logic                   ill_hit;
  logic [1:0]             ill_idx;
  logic                   stop;
  logic [1:0]             n0, n1;
  logic [PAYLOAD_W-1:0]   d0 [2];
  logic [PAYLOAD_W-1:0]   d1 [2];
  logic                   all_go;
  logic                   load;
  logic [SW-1:0]          c0_sum, c1_sum;
`ifdef DISPATCH_PERF_CNT_EN
  logic                   blk_res;
  logic [31:0]            stall_q, stall_d;
`endif

  assign run   = (state_q == RUN);
  assign flush = retire_flush_i;

  // Oldest-first walk: pick dispatching slots and fill RS ports
  always_comb begin
    disp    = '0;
    ill_hit = 1'b0;
    ill_idx = '0;
    stop    = 1'b0;
    n0      = '0;
    n1      = '0;
    d0[0]   = '0;
    d0[1]   = '0;
    d1[0]   = '0;
    d1[1]   = '0;
`ifdef DISPATCH_PERF_CNT_EN
    blk_res = 1'b0;
`endif
    for (int s = 0; s < 4; s++) begin
      if (run && grp_vld_q[s] && !stop) begin
        if (grp_pay_q[s][PAYLOAD_W-1]) begin
          ill_hit = 1'b1;
          ill_idx = 2'(s);
          stop    = 1'b1;
        end else if (!grp_rs_q[s]) begin
          if (n0 != 2'd2 &&
              credit0_q > CNT_W'(n0)) begin
            d0[n0[0]] = grp_pay_q[s];
            n0        = n0 + 2'd1;
            disp[s]   = 1'b1;
          end else begin
            stop = 1'b1;
`ifdef DISPATCH_PERF_CNT_EN
            blk_res = 1'b1;
`endif
          end
        end else begin
          if (n1 != 2'd2 &&
              credit1_q > CNT_W'(n1)) begin
            d1[n1[0]] = grp_pay_q[s];
            n1        = n1 + 2'd1;
            disp[s]   = 1'b1;
          end else begin
            stop = 1'b1;
`ifdef DISPATCH_PERF_CNT_EN
            blk_res = 1'b1;
`endif
          end
        end
      end
    end
  end

  assign all_go = ((grp_vld_q & ~disp) == 4'b0);
  assign dec.dec_ready_o = run & ~flush & all_go;
  assign load = dec.dec_ready_o & (|dec.dec_vld_i);

  assign rs0_wr_vld_o = flush ? 2'b00 :
                        {n0[1], n0[1] | n0[0]};
  assign rs1_wr_vld_o = flush ? 2'b00 :
                        {n1[1], n1[1] | n1[0]};
  assign rs0_wr_data_o = {d0[1], d0[0]};
  assign rs1_wr_data_o = {d1[1], d1[0]};

  assign illegal_o      = ill_hit & ~flush;
  assign illegal_slot_o = ill_idx;

  // Credits: return frees, consume writes, clamp at depth
  always_comb begin
    c0_sum = {1'b0, credit0_q}
           + SW'(rs0_free_i) - SW'(n0);
    c1_sum = {1'b0, credit1_q}
           + SW'(rs1_free_i) - SW'(n1);
    credit0_d = (c0_sum > SW'(RS_DEPTH)) ?
                DEPTH : c0_sum[CNT_W-1:0];
    credit1_d = (c1_sum > SW'(RS_DEPTH)) ?
                DEPTH : c1_sum[CNT_W-1:0];
    if (flush) begin
      credit0_d = DEPTH;
      credit1_d = DEPTH;
    end
  end

  // Holding register and RUN/HALT next state
  always_comb begin
    state_d   = state_q;
    grp_vld_d = grp_vld_q & ~disp;
    grp_rs_d  = grp_rs_q;
    for (int s = 0; s < 4; s++) begin
      grp_pay_d[s] = grp_pay_q[s];
    end
    if (ill_hit) begin
      grp_vld_d = '0;
      state_d   = HALT;
    end
    if (load) begin
      grp_vld_d = dec.dec_vld_i;
      grp_rs_d  = dec.dec_rs_id_i;
      for (int s = 0; s < 4; s++) begin
        grp_pay_d[s] =
          dec.dec_payload_i[s*PAYLOAD_W +: PAYLOAD_W];
      end
    end
    if (flush) begin
      grp_vld_d = '0;
      state_d   = RUN;
    end
  end

  // State, holding register and credit flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      grp_vld_q <= '0;
      grp_rs_q  <= '0;
      for (int s = 0; s < 4; s++) begin
        grp_pay_q[s] <= '0;
      end
      credit0_q <= DEPTH;
      credit1_q <= DEPTH;
    end else begin
      state_q   <= state_d;
      grp_vld_q <= grp_vld_d;
      grp_rs_q  <= grp_rs_d;
      for (int s = 0; s < 4; s++) begin
        grp_pay_q[s] <= grp_pay_d[s];
      end
      credit0_q <= credit0_d;
      credit1_q <= credit1_d;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  // Count cycles where a held slot waits on credit or port
  always_comb begin
    stall_d = stall_q;
    if (run && (|grp_vld_q) && blk_res) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter; survives flush, cleared by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
